// File: rtl/tank_plant_model_pkg.sv
// rtl/tank_plant_model_pkg.sv - shared sensor/pump bit map and word widths
package tank_plant_model_pkg;

   localparam int SENSOR_W     = 2;
   localparam int PUMP_W       = 2;
   localparam int SENSOR_I_BIT = 0;
   localparam int SENSOR_S_BIT = 1;
   localparam int PUMP_A_BIT   = 0;
   localparam int PUMP_B_BIT   = 1;

   typedef logic [SENSOR_W-1:0] sensor_word_t;
   typedef logic [PUMP_W-1:0]   pump_word_t;

endpackage

// File: rtl/tank_plant_model_if.sv
// rtl/tank_plant_model_if.sv - pump/sensor bundle between controller and plant
interface tank_plant_model_if
   import tank_plant_model_pkg::*;
#(
   parameter int LEVEL_WIDTH = 8
);

   pump_word_t             pumps;
   sensor_word_t           sensors;
   logic [LEVEL_WIDTH-1:0] level;
   logic                   tick;
   logic                   overflow;
   logic                   dry;

   // master = pump controller, slave = plant model
   modport master (output pumps, input sensors, level, tick, overflow, dry);
   modport slave  (input pumps, output sensors, level, tick, overflow, dry);

endinterface

// File: rtl/tank_plant_model_tick_divider.sv
// rtl/tank_plant_model_tick_divider.sv - free-running prescaler, tick_en on last count
module tick_divider #(
   parameter int TICK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   output logic tick_en
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q + 1'b1;
      if (count_q == LAST) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_en = (count_q == LAST);

endmodule

// File: rtl/tank_plant_model.sv
// rtl/tank_plant_model.sv - tank level integrator driven by pump commands, producing level sensors
module tank_plant_model
   import tank_plant_model_pkg::*;
#(
   parameter int LEVEL_WIDTH    = 8,
   parameter int LOW_THRESHOLD  = 64,
   parameter int HIGH_THRESHOLD = 192,
   parameter int FILL_RATE      = 4,
   parameter int DRAIN_RATE     = 1,
   parameter int TICK_DIV       = 4,
   parameter int INIT_LEVEL     = 0
) (
   input  logic               clock,
   input  logic               reset,
   tank_plant_model_if.slave  bus
);

   localparam int LW = LEVEL_WIDTH + 3;
   localparam logic signed [LW-1:0]   FILL_S  = LW'(FILL_RATE);
   localparam logic signed [LW-1:0]   DRAIN_S = LW'(DRAIN_RATE);
   localparam logic signed [LW-1:0]   MAX_S   = LW'((2 ** LEVEL_WIDTH) - 1);
   localparam logic [LEVEL_WIDTH-1:0] LOW_T   = LEVEL_WIDTH'(LOW_THRESHOLD);
   localparam logic [LEVEL_WIDTH-1:0] HIGH_T  = LEVEL_WIDTH'(HIGH_THRESHOLD);
   localparam logic [LEVEL_WIDTH-1:0] INIT_L  = LEVEL_WIDTH'(INIT_LEVEL);

   logic                   tick_en;
   logic signed [LW-1:0]   next_s;
   logic [LEVEL_WIDTH-1:0] level_q, level_d;
   sensor_word_t           sensors_q, sensors_d;
   logic                   tick_q, tick_d;
   logic                   overflow_q, overflow_d;
   logic                   dry_q, dry_d;

   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
      .clock   (clock),
      .reset   (reset),
      .tick_en (tick_en)
   );

   always_comb begin
      next_s = $signed({3'b000, level_q}) - DRAIN_S;
      if (bus.pumps[PUMP_A_BIT]) begin
         next_s = next_s + FILL_S;
      end
      if (bus.pumps[PUMP_B_BIT]) begin
         next_s = next_s + FILL_S;
      end

      level_d    = level_q;
      overflow_d = overflow_q;
      tick_d     = tick_en;
      // pumps only matter on the update edge; elsewhere level simply holds
      if (tick_en) begin
         if (next_s < 0) begin
            level_d = '0;
         end else if (next_s > MAX_S) begin
            level_d    = '1;
            overflow_d = 1'b1;
         end else begin
            level_d = next_s[LEVEL_WIDTH-1:0];
         end
      end

      // derived from the registered level, so they trail it by one clock
      sensors_d               = '0;
      sensors_d[SENSOR_I_BIT] = (level_q >= LOW_T);
      sensors_d[SENSOR_S_BIT] = (level_q >= HIGH_T);
      dry_d                   = (level_q == '0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level_q    <= INIT_L;
         sensors_q  <= '0;
         tick_q     <= 1'b0;
         overflow_q <= 1'b0;
         dry_q      <= 1'b0;
      end else begin
         level_q    <= level_d;
         sensors_q  <= sensors_d;
         tick_q     <= tick_d;
         overflow_q <= overflow_d;
         dry_q      <= dry_d;
      end
   end

   assign bus.level    = level_q;
   assign bus.sensors  = sensors_q;
   assign bus.tick     = tick_q;
   assign bus.overflow = overflow_q;
   assign bus.dry      = dry_q;

endmodule
